// File: rtl/k12_alu_ttl.sv
// K12 CPU 8-bit ALU: combinational result/condition datapath plus a registered
// {N,C,Z} flag store that updates only on ALU-class instructions.
module k12_alu_ttl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [15:0] inst,
  output logic [7:0]  res,
  output logic        cond,
  output logic [2:0]  flags
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MOV = 3'd7
  } op_t;

  typedef struct packed {
    logic [1:0] cls;
    logic       src;
    op_t        op;
    logic [1:0] csel;
    logic [7:0] imm;
  } dec_t;

  dec_t       d;
  logic       alu_cls;
  logic [7:0] opnd;
  logic [8:0] sum;
  logic       c_flag, n_flag, z_flag;

  assign d       = dec_t'(inst);
  assign alu_cls = (d.cls == 2'b00);
  assign opnd    = d.src ? d.imm : b;

  // SUB uses a + ~opnd + 1, so bit 8 is the "no borrow" carry directly.
  always_comb begin
    sum    = 9'd0;
    res    = 8'h00;
    c_flag = 1'b0;
    if (alu_cls) begin
      unique case (d.op)
        OP_ADD: begin
          sum    = {1'b0, a} + {1'b0, opnd};
          res    = sum[7:0];
          c_flag = sum[8];
        end
        OP_SUB: begin
          sum    = {1'b0, a} + {1'b0, ~opnd} + 9'd1;
          res    = sum[7:0];
          c_flag = sum[8];
        end
        OP_AND: res = a & opnd;
        OP_OR:  res = a | opnd;
        OP_XOR: res = a ^ opnd;
        OP_SHL: begin
          res    = {a[6:0], 1'b0};
          c_flag = a[7];
        end
        OP_SHR: begin
          res    = {1'b0, a[7:1]};
          c_flag = a[0];
        end
        OP_MOV: res = opnd;
        default: res = 8'h00;
      endcase
    end
  end

  assign z_flag = (res == 8'h00);
  assign n_flag = res[7];

  always_comb begin
    cond = 1'b0;
    if (alu_cls) begin
      unique case (d.csel)
        2'b00: cond = z_flag;
        2'b01: cond = c_flag;
        2'b10: cond = n_flag;
        2'b11: cond = ~z_flag;
        default: cond = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       flags <= 3'b000;
    else if (alu_cls) flags <= {n_flag, c_flag, z_flag};
  end

endmodule

// File: tb/tb_k12_alu_ttl.sv
// Directed and swept checks of k12_alu_ttl against an integer reference model,
// with expected res/cond queued at drive time and popped at compare time.
module tb_k12_alu_ttl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a, b;
  logic [15:0] inst;
  logic [7:0]  res;
  logic        cond;
  logic [2:0]  flags;

  int passed = 0;
  int total  = 0;

  logic [8:0] sb_q[$];
  logic [2:0] exp_flags;

  k12_alu_ttl dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .inst(inst),
    .res(res), .cond(cond), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {res[7:0], cond, N, C, Z}
  function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic [15:0] mi);
    int av, ov, r;
    logic c, n, z, cd;
    logic [7:0] rr;
    av = int'(ma);
    ov = mi[13] ? int'(mi[7:0]) : int'(mb);
    r = 0;
    c = 1'b0;
    if (mi[15:14] != 2'b00) return 12'h000;
    case (int'(mi[12:10]))
      0: begin r = av + ov; c = (r > 255); end
      1: begin r = av - ov + 256; c = (av >= ov); end
      2: r = av & ov;
      3: r = av | ov;
      4: r = av ^ ov;
      5: begin r = av * 2; c = (av >= 128); end
      6: begin r = av / 2; c = (av % 2) == 1; end
      default: r = ov;
    endcase
    rr = 8'(r % 256);
    z = (rr == 8'h00);
    n = (rr >= 8'h80);
    case (int'(mi[9:8]))
      0: cd = z;
      1: cd = c;
      2: cd = n;
      default: cd = !z;
    endcase
    return {rr, cd, n, c, z};
  endfunction

  task automatic check_flags(input string tag, input logic [2:0] e);
    total++;
    assert (flags === e) passed++;
    else $error("FAIL %s flags=%b expected=%b", tag, flags, e);
  endtask

  // Drive inputs mid-cycle, queue expectation, compare combinational outputs.
  task automatic apply(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [15:0] ti);
    logic [11:0] m;
    logic [8:0]  e;
    a = ta; b = tb_; inst = ti;
    m = model(ta, tb_, ti);
    sb_q.push_back(m[11:3]);
    #2;
    if (sb_q.size() == 0) begin
      total++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      total++;
      assert (res === e[8:1]) passed++;
      else $error("FAIL %s res=%h expected=%h (a=%h b=%h inst=%h)", tag, res, e[8:1], ta, tb_, ti);
      total++;
      assert (cond === e[0]) passed++;
      else $error("FAIL %s cond=%b expected=%b (a=%h b=%h inst=%h)", tag, cond, e[0], ta, tb_, ti);
    end
  endtask

  // Clock edge with flag model update, then check flags just after the edge.
  task automatic tick(input string tag);
    logic [11:0] m;
    m = model(a, b, inst);
    if (rst_n && inst[15:14] == 2'b00) exp_flags = m[2:0];
    @(posedge clk);
    #1;
    check_flags(tag, exp_flags);
  endtask

  logic [7:0] pats [8] = '{8'h00, 8'h01, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

  initial begin
    rst_n = 1'b0; a = 8'h00; b = 8'h00; inst = 16'h0000;
    exp_flags = 3'b000;
    #1;
    check_flags("reset_async", 3'b000);
    @(posedge clk); #1;
    check_flags("reset_held", 3'b000);
    rst_n = 1'b1;

    apply("add_wrap81", 8'h81, 8'h81, 16'h0000);
    tick("add_flags");
    check_flags("add_flags_010", 3'b010);

    apply("sub_zero", 8'h7E, 8'h7E, 16'h0400);
    apply("sub_borrow", 8'h00, 8'h01, 16'h0400);
    apply("and_imm", 8'hFF, 8'h5A, 16'h287E);
    apply("and_imm_b", 8'hFF, 8'hA5, 16'h287E);
    apply("shl_c", 8'h81, 8'h00, 16'h1500);
    apply("shr_c", 8'h81, 8'h00, 16'h1900);
    apply("add_ff01", 8'hFF, 8'h01, 16'h0100);
    tick("add_ff01_flags");
    check_flags("add_ff01_011", 3'b011);

    apply("sub_0001_n", 8'h00, 8'h01, 16'h0600);
    tick("sub_0001_flags");
    check_flags("sub_0001_100", 3'b100);

    // Non-ALU class: zero outputs, flags hold across an edge.
    apply("cls1", 8'h81, 8'h81, 16'h4000);
    tick("cls1_hold");
    check_flags("cls1_hold_100", 3'b100);
    apply("cls2", 8'hFF, 8'h01, 16'h8300);
    apply("cls3", 8'h00, 8'h00, 16'hFFFF);
    tick("cls3_hold");

    // Async reset between edges; combinational outputs unaffected.
    apply("pre_rst", 8'h81, 8'h81, 16'h0000);
    tick("pre_rst_flags");
    #2;
    rst_n = 1'b0;
    exp_flags = 3'b000;
    #1;
    check_flags("async_rst", 3'b000);
    apply("during_rst", 8'h81, 8'h81, 16'h0000);
    tick("rst_held_edge");
    #2;
    rst_n = 1'b1;

    for (int op = 0; op < 8; op++)
      for (int src = 0; src < 2; src++)
        for (int cs = 0; cs < 4; cs++)
          for (int ia = 0; ia < 8; ia++)
            for (int ib = 0; ib < 8; ib++) begin
              logic [15:0] wi;
              wi = {2'b00, 1'(src), 3'(op), 2'(cs), pats[7 - ib]};
              apply("sweep", pats[ia], pats[ib], wi);
              if (ib == 0 || ib == 5) tick("sweep_flags");
            end

    if (sb_q.size() != 0) begin
      total++;
      $error("FAIL scoreboard_leftover size=%0d expected=0", sb_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
